// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the fetch PC, keeps one SRAM-like fetch in flight, presents inst/PC to ID.
// Optional misaligned-PC trap enabled with `define IF_PC_ALIGN_CHECK_EN.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_to_addr_i,
  input  logic        stall_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_adel_o
);

`ifdef IF_PC_ALIGN_CHECK_EN
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_ERR} state_e;
`else
  typedef enum logic [1:0] {S_REQ, S_WAIT} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [31:0] br_tgt_q, br_tgt_d;
  logic        br_pend_q, br_pend_d;
  logic        drop_q, drop_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        req;
`ifdef IF_PC_ALIGN_CHECK_EN
  logic        adel_q, adel_d;
`endif

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    inflight_pc_d = inflight_pc_q;
    br_tgt_d      = br_tgt_q;
    br_pend_d     = br_pend_q;
    drop_d        = drop_q;
    inst_valid_d  = inst_valid_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    req           = 1'b0;
`ifdef IF_PC_ALIGN_CHECK_EN
    adel_d        = adel_q;
`endif
    if (inst_valid_q && !stall_i) inst_valid_d = 1'b0;

    case (state_q)
      S_REQ: begin
`ifdef IF_PC_ALIGN_CHECK_EN
        if (fetch_pc_q[1:0] != 2'b00) begin
          state_d      = S_ERR;
          inst_valid_d = 1'b1;
          adel_d       = 1'b1;
          inst_d       = 32'h0;
          inst_pc_d    = fetch_pc_q;
        end else
`endif
        begin
          req = !(inst_valid_q && stall_i);
          if (req && inst_addr_ok_i) begin
            // The fetch accepted here is the delay slot of any branch seen now or earlier.
            state_d       = S_WAIT;
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = branch_flag_i ? branch_to_addr_i :
                            br_pend_q     ? br_tgt_q : fetch_pc_q + 32'd4;
            br_pend_d     = 1'b0;
          end else if (branch_flag_i) begin
            br_pend_d = 1'b1;
            br_tgt_d  = branch_to_addr_i;
          end
        end
      end
      S_WAIT: begin
        if (branch_flag_i) begin
          br_pend_d = 1'b1;
          br_tgt_d  = branch_to_addr_i;
        end
        if (inst_data_ok_i) begin
          state_d = S_REQ;
          if (drop_q) begin
            drop_d = 1'b0;
          end else begin
            inst_d       = inst_rdata_i;
            inst_pc_d    = inflight_pc_q;
            inst_valid_d = 1'b1;
          end
        end
      end
`ifdef IF_PC_ALIGN_CHECK_EN
      S_ERR: inst_valid_d = 1'b1;
`endif
      default: state_d = S_REQ;
    endcase

    // Flush overrides everything above; a fetch still in flight afterwards is marked for discard.
    if (flush_i) begin
      fetch_pc_d   = new_pc_i;
      br_pend_d    = 1'b0;
      inst_valid_d = 1'b0;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
`ifdef IF_PC_ALIGN_CHECK_EN
      adel_d       = 1'b0;
`endif
      if (state_d == S_WAIT) begin
        drop_d = 1'b1;
      end else begin
        state_d = S_REQ;
        drop_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_REQ;
      fetch_pc_q    <= RESET_PC;
      inflight_pc_q <= RESET_PC;
      br_tgt_q      <= 32'h0;
      br_pend_q     <= 1'b0;
      drop_q        <= 1'b0;
      inst_valid_q  <= 1'b0;
      inst_q        <= 32'h0;
      inst_pc_q     <= 32'h0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      inflight_pc_q <= inflight_pc_d;
      br_tgt_q      <= br_tgt_d;
      br_pend_q     <= br_pend_d;
      drop_q        <= drop_d;
      inst_valid_q  <= inst_valid_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
    end
  end

`ifdef IF_PC_ALIGN_CHECK_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) adel_q <= 1'b0;
    else       adel_q <= adel_d;
  end
  assign inst_adel_o = adel_q;
`else
  assign inst_adel_o = 1'b0;
`endif

  assign inst_req_o   = req && !rst_i;
  assign inst_addr_o  = fetch_pc_q;
  assign inst_valid_o = inst_valid_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: reset, streaming, branch delay slot, flush/drop, stall hold, wrap, late data after reset.
module tb_if_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1, flush_i = 1'b0, branch_flag_i = 1'b0, stall_i = 1'b0;
  logic [31:0] new_pc_i = 32'h0, branch_to_addr_i = 32'h0, inst_rdata_i = 32'h0;
  logic        inst_addr_ok_i = 1'b0, inst_data_ok_i = 1'b0;
  logic        inst_req_o, inst_valid_o, inst_adel_o;
  logic [31:0] inst_addr_o, inst_o, inst_pc_o;
  int total = 0, bad = 0;

  if_fetch_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .new_pc_i(new_pc_i),
    .branch_flag_i(branch_flag_i), .branch_to_addr_i(branch_to_addr_i), .stall_i(stall_i),
    .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o), .inst_addr_ok_i(inst_addr_ok_i),
    .inst_data_ok_i(inst_data_ok_i), .inst_rdata_i(inst_rdata_i), .inst_valid_o(inst_valid_o),
    .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_adel_o(inst_adel_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one edge, then settle so outputs are sampled away from it
  task automatic step();
    @(posedge clk); #1;
  endtask

  // one complete fetch with a 1-cycle memory; checks address, then the registered result
  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    while (!inst_req_o && n < 20) begin step(); n++; end
    chk({tag, "_req"}, {31'h0, inst_req_o}, 32'h1);
    chk({tag, "_addr"}, inst_addr_o, a);
    inst_addr_ok_i = 1'b1; step();
    inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b1; inst_rdata_i = d; #1;
    chk({tag, "_noreq_wait"}, {31'h0, inst_req_o}, 32'h0);
    step();
    inst_data_ok_i = 1'b0; #1;
    chk({tag, "_valid"}, {31'h0, inst_valid_o}, 32'h1);
    chk({tag, "_inst"}, inst_o, d);
    chk({tag, "_pc"}, inst_pc_o, a);
  endtask

  initial begin
    // reset
    step(); #1;
    chk("rst_req", {31'h0, inst_req_o}, 32'h0);
    step();
    rst_i = 1'b0; #1;
    chk("rst_req_after", {31'h0, inst_req_o}, 32'h1);
    chk("rst_addr", inst_addr_o, 32'hBFC0_0000);
    chk("rst_valid", {31'h0, inst_valid_o}, 32'h0);
    chk("rst_inst", inst_o, 32'h0);
    chk("rst_pc", inst_pc_o, 32'h0);
    chk("rst_adel", {31'h0, inst_adel_o}, 32'h0);

    // stream
    fetch("f0", 32'hBFC0_0000, 32'h2401_0001);
    fetch("f4", 32'hBFC0_0004, 32'h1111_0004);

    // branch resolved while 0x..08 is in WAIT
    chk("f8_addr", inst_addr_o, 32'hBFC0_0008);
    inst_addr_ok_i = 1'b1; step();
    inst_addr_ok_i = 1'b0;
    branch_flag_i = 1'b1; branch_to_addr_i = 32'h8000_0100;
    inst_data_ok_i = 1'b1; inst_rdata_i = 32'h1111_0008;
    step();
    branch_flag_i = 1'b0; inst_data_ok_i = 1'b0; #1;
    chk("f8_pc", inst_pc_o, 32'hBFC0_0008);
    fetch("dslot", 32'hBFC0_000C, 32'h1111_000C);
    fetch("btgt", 32'h8000_0100, 32'h2222_0100);

    // flush while in WAIT: returning data dropped
    chk("fw_addr", inst_addr_o, 32'h8000_0104);
    inst_addr_ok_i = 1'b1; step();
    inst_addr_ok_i = 1'b0; flush_i = 1'b1; new_pc_i = 32'hBFC0_0380;
    step();
    flush_i = 1'b0; #1;
    chk("fw_valid_clr", {31'h0, inst_valid_o}, 32'h0);
    chk("fw_noreq", {31'h0, inst_req_o}, 32'h0);
    inst_data_ok_i = 1'b1; inst_rdata_i = 32'hDEAD_BEEF;
    step();
    inst_data_ok_i = 1'b0; #1;
    chk("fw_drop_valid", {31'h0, inst_valid_o}, 32'h0);
    chk("fw_drop_inst", inst_o, 32'h2222_0100);
    chk("fw_req", {31'h0, inst_req_o}, 32'h1);
    chk("fw_new_addr", inst_addr_o, 32'hBFC0_0380);

    // flush and branch together: flush wins
    flush_i = 1'b1; new_pc_i = 32'hBFC0_0380;
    branch_flag_i = 1'b1; branch_to_addr_i = 32'h1234_5678;
    step();
    flush_i = 1'b0; branch_flag_i = 1'b0; #1;
    fetch("fb", 32'hBFC0_0380, 32'h3333_0380);

    // stall hold with valid data
    stall_i = 1'b1; #1;
    chk("st_noreq0", {31'h0, inst_req_o}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("st_noreq", {31'h0, inst_req_o}, 32'h0);
      chk("st_valid", {31'h0, inst_valid_o}, 32'h1);
      chk("st_inst", inst_o, 32'h3333_0380);
      chk("st_pc", inst_pc_o, 32'hBFC0_0380);
    end
    stall_i = 1'b0; #1;
    chk("st_req_back", {31'h0, inst_req_o}, 32'h1);
    chk("st_addr", inst_addr_o, 32'hBFC0_0384);
    step();
    chk("st_consumed", {31'h0, inst_valid_o}, 32'h0);

    // flush with same-cycle acceptance: in-flight fetch discarded
    flush_i = 1'b1; new_pc_i = 32'hFFFF_FFFC; inst_addr_ok_i = 1'b1;
    step();
    flush_i = 1'b0; inst_addr_ok_i = 1'b0; #1;
    chk("fa_noreq", {31'h0, inst_req_o}, 32'h0);
    inst_data_ok_i = 1'b1; inst_rdata_i = 32'hBAD0_BAD0;
    step();
    inst_data_ok_i = 1'b0; #1;
    chk("fa_drop_valid", {31'h0, inst_valid_o}, 32'h0);

    // PC wrap
    fetch("wrap", 32'hFFFF_FFFC, 32'h4444_FFFC);
    chk("wrap_next", inst_addr_o, 32'h0000_0000);

    // reset mid-WAIT: late data_ok ignored
    inst_addr_ok_i = 1'b1; step();
    inst_addr_ok_i = 1'b0; rst_i = 1'b1; step();
    rst_i = 1'b0; #1;
    chk("rw_req", {31'h0, inst_req_o}, 32'h1);
    chk("rw_addr", inst_addr_o, 32'hBFC0_0000);
    chk("rw_valid", {31'h0, inst_valid_o}, 32'h0);
    inst_data_ok_i = 1'b1; inst_rdata_i = 32'h5555_5555;
    step();
    inst_data_ok_i = 1'b0; #1;
    chk("rw_late_valid", {31'h0, inst_valid_o}, 32'h0);
    chk("rw_late_inst", inst_o, 32'h0);
    chk("rw_still_req", {31'h0, inst_req_o}, 32'h1);

`ifdef IF_PC_ALIGN_CHECK_EN
    flush_i = 1'b1; new_pc_i = 32'h8000_0002; step();
    flush_i = 1'b0; #1;
    chk("al_noreq", {31'h0, inst_req_o}, 32'h0);
    step();
    chk("al_valid", {31'h0, inst_valid_o}, 32'h1);
    chk("al_adel", {31'h0, inst_adel_o}, 32'h1);
    chk("al_inst", inst_o, 32'h0);
    chk("al_pc", inst_pc_o, 32'h8000_0002);
    step();
    chk("al_hold", {31'h0, inst_adel_o}, 32'h1);
    chk("al_hold_noreq", {31'h0, inst_req_o}, 32'h0);
    flush_i = 1'b1; new_pc_i = 32'h8000_0000; step();
    flush_i = 1'b0; #1;
    chk("al_rec_adel", {31'h0, inst_adel_o}, 32'h0);
    chk("al_rec_valid", {31'h0, inst_valid_o}, 32'h0);
    fetch("al_rec", 32'h8000_0000, 32'h6666_0000);
`else
    chk("adel_tied", {31'h0, inst_adel_o}, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
